reorder_buffer: RTL

- Circular in-order retirement buffer that directly consumes the common data bus driven by the CDB arbiter.
- Dispatch allocates one entry per cycle and returns its tag; functional units later broadcast results against that tag.
- Completed entries retire strictly in program order, one per cycle, from the head.
- A mispredicted control-flow instruction triggers a full flush and a fetch redirect when it retires.

---
 rtl/reorder_buffer_if.sv | 44 ++++
 rtl/reorder_buffer.sv | 118 +++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Dispatch, common-data-bus and retirement signals between the core and the reorder buffer.
// master drives dispatch/CDB and observes commit; slave is the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned ROB   = 2
);
    logic               dispatchValid;
    logic [4:0]         dispatchDestReg;
    logic               dispatchRegWrite;
    logic               dispatchIsControl;
    logic [WIDTH:0]     dispatchPredTarget;
    logic [ROB:0]       allocEntry;
    logic               robFull;

    logic               cdbValid;
    logic [ROB:0]       cdbRobEntry;
    logic [WIDTH:0]     cdbResult;
    logic               cdbIsControl;
    logic [WIDTH:0]     cdbTargetAddress;

    logic               commitValid;
    logic [4:0]         commitDestReg;
    logic               commitRegWrite;
    logic [WIDTH:0]     commitResult;
    logic [ROB:0]       commitEntry;
    logic               flush;
    logic [WIDTH:0]     redirectAddress;

    modport master (
        output dispatchValid, dispatchDestReg, dispatchRegWrite, dispatchIsControl,
               dispatchPredTarget, cdbValid, cdbRobEntry, cdbResult, cdbIsControl,
               cdbTargetAddress,
        input  allocEntry, robFull, commitValid, commitDestReg, commitRegWrite,
               commitResult, commitEntry, flush, redirectAddress
    );

    modport slave (
        input  dispatchValid, dispatchDestReg, dispatchRegWrite, dispatchIsControl,
               dispatchPredTarget, cdbValid, cdbRobEntry, cdbResult, cdbIsControl,
               cdbTargetAddress,
        output allocEntry, robFull, commitValid, commitDestReg, commitRegWrite,
               commitResult, commitEntry, flush, redirectAddress
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer fed by the CDB; retires one completed entry per cycle
// from the head and flushes everything behind a mispredicted branch when it retires.
module reorder_buffer #(
    parameter int unsigned WIDTH = 31,
    parameter int unsigned ROB   = 2
) (
    input  logic             clk,
    input  logic             resetN,
    reorder_buffer_if.slave  rob
);
    localparam int unsigned DEPTH = 2 ** (ROB + 1);
    localparam int unsigned PW    = ROB + 2;
    localparam int unsigned DW    = WIDTH + 1;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    count;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] mispredict;

    logic [4:0]       dest_reg      [DEPTH];
    logic             reg_write     [DEPTH];
    logic             is_control    [DEPTH];
    logic [DW-1:0]    pred_target   [DEPTH];
    logic [DW-1:0]    result        [DEPTH];
    logic [DW-1:0]    actual_target [DEPTH];

    logic [ROB:0]     h_idx;
    logic [ROB:0]     t_idx;
    logic [ROB:0]     c_idx;
    logic             alloc_go;
    logic             cdb_go;
    logic             commit_go;
    logic             flush_go;

    assign count          = tail - head;
    assign h_idx          = head[ROB:0];
    assign t_idx          = tail[ROB:0];
    assign c_idx          = rob.cdbRobEntry;
    assign rob.robFull    = (count == PW'(DEPTH));
    assign rob.allocEntry = t_idx;

    // A broadcast aimed at the entry being allocated sees busy=0 and is dropped here.
    assign alloc_go  = rob.dispatchValid & ~rob.robFull;
    assign cdb_go    = rob.cdbValid & busy[c_idx];
    assign commit_go = busy[h_idx] & ready[h_idx];
    assign flush_go  = commit_go & mispredict[h_idx];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            head                <= '0;
            tail                <= '0;
            busy                <= '0;
            ready               <= '0;
            mispredict          <= '0;
            rob.commitValid     <= 1'b0;
            rob.commitDestReg   <= '0;
            rob.commitRegWrite  <= 1'b0;
            rob.commitResult    <= '0;
            rob.commitEntry     <= '0;
            rob.flush           <= 1'b0;
            rob.redirectAddress <= '0;
        end else begin
            rob.commitValid <= commit_go;
            rob.flush       <= flush_go;
            if (commit_go) begin
                rob.commitDestReg  <= dest_reg[h_idx];
                rob.commitRegWrite <= reg_write[h_idx];
                rob.commitResult   <= result[h_idx];
                rob.commitEntry    <= h_idx;
            end
            if (flush_go) begin
                // Squash: same-edge allocation and CDB writes are discarded with the rest.
                rob.redirectAddress <= actual_target[h_idx];
                busy       <= '0;
                ready      <= '0;
                mispredict <= '0;
                head       <= '0;
                tail       <= '0;
            end else begin
                if (alloc_go) begin
                    busy[t_idx]       <= 1'b1;
                    ready[t_idx]      <= 1'b0;
                    mispredict[t_idx] <= 1'b0;
                    tail              <= tail + PW'(1);
                end
                if (cdb_go) begin
                    ready[c_idx] <= 1'b1;
                    if (rob.cdbIsControl) begin
                        mispredict[c_idx] <= is_control[c_idx] &
                                             (rob.cdbTargetAddress != pred_target[c_idx]);
                    end
                end
                if (commit_go) begin
                    busy[h_idx] <= 1'b0;
                    head        <= head + PW'(1);
                end
            end
        end
    end

    // Payload storage; validity is tracked solely by the busy/ready bits above.
    always_ff @(posedge clk) begin
        if (alloc_go) begin
            dest_reg[t_idx]    <= rob.dispatchDestReg;
            reg_write[t_idx]   <= rob.dispatchRegWrite;
            is_control[t_idx]  <= rob.dispatchIsControl;
            pred_target[t_idx] <= rob.dispatchPredTarget;
        end
        if (cdb_go) begin
            result[c_idx] <= rob.cdbResult;
            if (rob.cdbIsControl) begin
                actual_target[c_idx] <= rob.cdbTargetAddress;
            end
        end
    end
endmodule
